// File: rtl/fpa_pkg.sv
// Shared datapath constants and sequencer state encoding for the FPA shift path.
package fpa_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AMT_W = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRevIn,
    StShift,
    StRevOut,
    StDone
  } state_e;

endpackage

// File: rtl/shift_sequencer_bitrev.sv
// Combinational bit reversal: data_o[i] = data_i[Width-1-i] when s_i, pass-through otherwise.
module shift_sequencer_bitrev #(
  parameter int unsigned Width = fpa_pkg::WIDTH
) (
  input  logic [Width-1:0] data_i,
  input  logic             s_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] reversed;

  for (genvar i = 0; i < Width; i++) begin : g_rev
    assign reversed[i] = data_i[Width-1-i];
  end

  assign data_o = s_i ? reversed : data_i;

endmodule

// File: rtl/shift_sequencer.sv
// Serial shifter: one bit per cycle through a single left shifter; right shifts are
// done by reversing the operand before and after the left-shift loop.
module shift_sequencer #(
  parameter int unsigned WIDTH = fpa_pkg::WIDTH,
  parameter int unsigned AMT_W = fpa_pkg::AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             busy
);

  import fpa_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             sticky_q, sticky_d;

  logic             rev_sel;
  logic [WIDTH-1:0] r_rev;

  assign rev_sel = (state_q == StRevIn) || (state_q == StRevOut);

  shift_sequencer_bitrev #(
    .Width (WIDTH)
  ) u_bitrev (
    .data_i (r_q),
    .s_i    (rev_sel),
    .data_o (r_rev)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (in_valid) state_d = in_dir ? StRevIn : StShift;
      StRevIn:  state_d = StShift;
      StShift:  if (cnt_q == '0) state_d = dir_q ? StRevOut : StDone;
      StRevOut: state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    out_valid  = (state_q == StDone);
    out_data   = out_valid ? r_q : '0;
    out_sticky = out_valid & sticky_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    r_d      = r_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    sticky_d = sticky_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          r_d      = in_data;
          cnt_d    = in_amt;
          dir_d    = in_dir;
          sticky_d = 1'b0;
        end
      end
      StRevIn, StRevOut: r_d = r_rev;
      StShift: begin
        if (cnt_q != '0) begin
          r_d   = {r_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - AMT_W'(1);
          // In reversed form the bits leaving the top are the original low bits.
          if (dir_q) sticky_d = sticky_q | r_q[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised bench for shift_sequencer against a plain shift/mask reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sticky;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(
    .WIDTH (32),
    .AMT_W (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_dir     (in_dir),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic do_req(input logic [31:0] d, input logic [4:0] a, input logic dr,
                        input int stall, input bit pre_ready);
    logic [31:0] exp_d;
    logic        exp_s;
    int          exp_lat;
    int          lat;
    bit          seen;
    exp_d   = dr ? (d >> a) : (d << a);
    exp_s   = dr ? (({32'b0, d} & ((64'd1 << a) - 64'd1)) != 64'd0) : 1'b0;
    exp_lat = dr ? int'(a) + 3 : int'(a) + 1;

    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);

    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_dir    = dr;
    out_ready = pre_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom);
    in_dir   = 1'($urandom);

    lat  = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      check_eq("timeout_out_valid", 32'd0, 32'd1);
      return;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("out_data", out_data, exp_d);
    check_eq("out_sticky", 32'(out_sticky), 32'(exp_s));
    check_eq("busy_done", 32'(busy), 32'd1);
    check_eq("in_ready_done", 32'(in_ready), 32'd0);

    out_ready = (stall == 0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_data", out_data, exp_d);
      check_eq("stall_sticky", 32'(out_sticky), 32'(exp_s));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_sticky", 32'(out_sticky), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    do_req(32'h0000_00F1, 5'd4, 1'b0, 0, 1'b0);
    do_req(32'h8000_0013, 5'd4, 1'b1, 0, 1'b1);
    do_req(32'hFFFF_FFFF, 5'd31, 1'b1, 0, 1'b0);
    do_req(32'hFFFF_FFFF, 5'd31, 1'b0, 0, 1'b1);
    do_req(32'h1234_5678, 5'd0, 1'b0, 0, 1'b0);
    do_req(32'h1234_5678, 5'd0, 1'b1, 0, 1'b0);
    do_req(32'hDEAD_BEEF, 5'd7, 1'b1, 10, 1'b0);
    do_req(32'h0F0F_0F0F, 5'd3, 1'b0, 10, 1'b0);

    // Abort a right shift partway through the shift loop.
    in_valid = 1'b1;
    in_data  = 32'hA5A5_5A5A;
    in_amt   = 5'd20;
    in_dir   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_out_data", out_data, 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    out_ready = 1'b0;
    check_eq("abort_no_result", 32'(seen_valid), 32'd0);
    do_req(32'hA5A5_5A5A, 5'd20, 1'b1, 0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      do_req($urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
